// File: rtl/mul_bitlen_frontend.sv
// Reducer front end: iterative radix-2^DIGIT_LENGTH multiply plus modulus bit length.
// Result appears NUM_DIGITS+1 cycles after accept; start_i is ignored unless ready_o is high.
module mul_bitlen_frontend #(
  parameter int DATA_LENGTH  = 64,
  parameter int OP_LENGTH    = 32,
  parameter int DIGIT_LENGTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [OP_LENGTH-1:0]   a_i,
  input  logic [OP_LENGTH-1:0]   b_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  output logic                   ready_o,
  output logic [DATA_LENGTH-1:0] x_o,
  output logic [DATA_LENGTH-1:0] m_o,
  output logic [DATA_LENGTH-1:0] m_bl_o,
  output logic                   bad_mod_o,
  output logic                   valid_o
);

  localparam int NUM_DIGITS = OP_LENGTH / DIGIT_LENGTH;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int ACC_W      = 2 * OP_LENGTH;
  localparam int PP_W       = OP_LENGTH + DIGIT_LENGTH;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e                 state_q, state_d;
  logic [OP_LENGTH-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0] x_q, x_d, m_q, m_d, m_bl_q, m_bl_d;
  logic                   bad_q, bad_d;

  int                     shamt;
  logic [DIGIT_LENGTH-1:0] digit;
  logic [PP_W-1:0]        pp;
  logic [ACC_W-1:0]       sum;
  logic [DATA_LENGTH-1:0] m_bl_enc;

  // One digit of b per cycle, shifted into place and accumulated.
  always_comb begin
    shamt = int'(cnt_q) * DIGIT_LENGTH;
    digit = DIGIT_LENGTH'(b_q >> shamt);
    pp    = PP_W'(a_q) * PP_W'(digit);
    sum   = acc_q + (ACC_W'(pp) << shamt);
  end

  // Priority encode: the highest set bit wins because it is visited last.
  always_comb begin
    m_bl_enc = '0;
    for (int i = 0; i < DATA_LENGTH; i++) begin
      if (m_i[i]) m_bl_enc = DATA_LENGTH'(i + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    m_d     = m_q;
    m_bl_d  = m_bl_q;
    bad_d   = bad_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          m_d     = m_i;
          m_bl_d  = m_bl_enc;
          bad_d   = ~|m_i[DATA_LENGTH-1:1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
          x_d     = DATA_LENGTH'(sum);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      m_q     <= '0;
      m_bl_q  <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      m_q     <= m_d;
      m_bl_q  <= m_bl_d;
      bad_q   <= bad_d;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign valid_o   = (state_q == DONE);
  assign x_o       = x_q;
  assign m_o       = m_q;
  assign m_bl_o    = m_bl_q;
  assign bad_mod_o = bad_q;

endmodule
